// File: rtl/param_locksystem_if.sv
// Keypad-side bundle of the combination lock: digit strobe, control
// requests and the registered lock/alarm/status outputs.
interface param_locksystem_if #(
    parameter int DIGIT_W = 3,
    parameter int TRIES_W = 2
);
    logic [DIGIT_W-1:0] in;
    logic               in_valid;
    logic               prog_en;
    logic               relock;
    logic               locked;
    logic               alarm;
    logic [1:0]         selsw;
    logic               entimer;
    logic [TRIES_W-1:0] tries_left;

    modport master (
        output in, in_valid, prog_en, relock,
        input  locked, alarm, selsw, entimer, tries_left
    );

    modport slave (
        input  in, in_valid, prog_en, relock,
        output locked, alarm, selsw, entimer, tries_left
    );
endinterface

// File: rtl/param_locksystem.sv
// Parametrised combination lock: code entry, tries/lockout, auto-relock,
// entry timeout and in-field code programming.
module param_locksystem #(
    parameter int DIGIT_W = 3,
    parameter int CODE_LEN = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {3'd1, 3'd2, 3'd3, 3'd5},
    parameter int MAX_TRIES = 3,
    parameter int UNLOCK_CYCLES = 8,
    parameter int LOCKOUT_CYCLES = 12,
    parameter int ENTRY_TIMEOUT = 16
) (
    input logic clk,
    input logic reset,
    param_locksystem_if.slave io
);
    localparam int CW   = CODE_LEN * DIGIT_W;
    localparam int PW   = (CODE_LEN - 1) * DIGIT_W;
    localparam int TRW  = $clog2(MAX_TRIES + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(CODE_LEN);
    localparam int EW   = $clog2(ENTRY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ENTRY, OPEN, LOCKOUT, PROGRAM} state_t;

    state_t         state, state_d;
    logic [CW-1:0]  code, code_d;
    logic [PW-1:0]  entry, entry_d;
    logic [PW-1:0]  shadow, shadow_d;
    logic [IW-1:0]  idx, idx_d;
    logic [TW-1:0]  tmr, tmr_d;
    logic [EW-1:0]  idle, idle_d;
    logic [TRW-1:0] tries, tries_d;
    logic           locked, locked_d;
    logic           alarm, alarm_d;
    logic [1:0]     selsw, selsw_d;
    logic           entimer, entimer_d;

    // Only the first CODE_LEN-1 digits are held; the live digit completes the word.
    logic [CW-1:0] ent_full, shd_full;
    logic          last, timeout;

    assign ent_full = {entry, io.in};
    assign shd_full = {shadow, io.in};
    assign last     = (idx == IW'(CODE_LEN - 1));
    assign timeout  = (idle == EW'(ENTRY_TIMEOUT - 1));

    always_comb begin
        state_d  = state;
        code_d   = code;
        entry_d  = entry;
        shadow_d = shadow;
        idx_d    = idx;
        tmr_d    = tmr;
        idle_d   = idle;
        tries_d  = tries;
        unique case (state)
            IDLE, ENTRY: begin
                if (io.in_valid) begin
                    idle_d  = '0;
                    entry_d = ent_full[PW-1:0];
                    if (last) begin
                        idx_d = '0;
                        if (ent_full == code) begin
                            state_d = OPEN;
                            tries_d = TRW'(MAX_TRIES);
                            tmr_d   = TW'(UNLOCK_CYCLES - 1);
                        end else if (tries > TRW'(1)) begin
                            state_d = IDLE;
                            tries_d = tries - TRW'(1);
                        end else begin
                            state_d = LOCKOUT;
                            tries_d = '0;
                            tmr_d   = TW'(LOCKOUT_CYCLES - 1);
                        end
                    end else begin
                        idx_d   = idx + IW'(1);
                        state_d = ENTRY;
                    end
                end else if (state == ENTRY) begin
                    if (timeout) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle + EW'(1);
                    end
                end
            end
            OPEN: begin
                if (io.relock) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if (io.prog_en) begin
                    state_d = PROGRAM;
                    tmr_d   = '0;
                    idx_d   = '0;
                    idle_d  = '0;
                end else if (tmr == '0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr - TW'(1);
                end
            end
            LOCKOUT: begin
                if (tmr == '0) begin
                    state_d = IDLE;
                    tries_d = TRW'(MAX_TRIES);
                end else begin
                    tmr_d = tmr - TW'(1);
                end
            end
            PROGRAM: begin
                if (io.in_valid) begin
                    idle_d   = '0;
                    shadow_d = shd_full[PW-1:0];
                    if (last) begin
                        code_d  = shd_full;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx + IW'(1);
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    idle_d  = '0;
                end else begin
                    idle_d = idle + EW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        locked_d  = !(state_d == OPEN || state_d == PROGRAM);
        alarm_d   = (state_d == LOCKOUT);
        entimer_d = (state_d == OPEN || state_d == LOCKOUT);
        selsw_d   = 2'b00;
        unique case (state_d)
            OPEN:    selsw_d = 2'b01;
            LOCKOUT: selsw_d = 2'b10;
            PROGRAM: selsw_d = 2'b11;
            default: selsw_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            code    <= DEFAULT_CODE;
            entry   <= '0;
            shadow  <= '0;
            idx     <= '0;
            tmr     <= '0;
            idle    <= '0;
            tries   <= TRW'(MAX_TRIES);
            locked  <= 1'b1;
            alarm   <= 1'b0;
            selsw   <= 2'b00;
            entimer <= 1'b0;
        end else begin
            state   <= state_d;
            code    <= code_d;
            entry   <= entry_d;
            shadow  <= shadow_d;
            idx     <= idx_d;
            tmr     <= tmr_d;
            idle    <= idle_d;
            tries   <= tries_d;
            locked  <= locked_d;
            alarm   <= alarm_d;
            selsw   <= selsw_d;
            entimer <= entimer_d;
        end
    end

    assign io.locked     = locked;
    assign io.alarm      = alarm;
    assign io.selsw      = selsw;
    assign io.entimer    = entimer;
    assign io.tries_left = tries;
endmodule

// File: tb/tb_param_locksystem.sv
// Scoreboard bench for param_locksystem: directed digit sequences push
// cycle-tagged expected outputs; a negedge monitor pops and compares.
module tb_param_locksystem;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    param_locksystem_if #(.DIGIT_W(3), .TRIES_W(2)) io ();

    param_locksystem dut (
        .clk(clk),
        .reset(reset),
        .io(io)
    );

    // {locked, alarm, selsw, entimer}
    localparam logic [4:0] S_IDLE = 5'b10000;
    localparam logic [4:0] S_OPEN = 5'b00011;
    localparam logic [4:0] S_LOCK = 5'b11101;
    localparam logic [4:0] S_PROG = 5'b00110;

    typedef struct {
        int         tag;
        string      nm;
        logic [6:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [6:0] act;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= cyc) begin
            e = q.pop_front();
            checks++;
            act = {io.locked, io.alarm, io.selsw, io.entimer, io.tries_left};
            if (e.tag < cyc) begin
                errors++;
                $display("FAIL %s: not sampled at cycle %0d (now %0d)", e.nm, e.tag, cyc);
            end else if (act !== e.v) begin
                errors++;
                $display("FAIL %s: cycle %0d got %b want %b", e.nm, cyc, act, e.v);
            end
        end
    end

    task automatic ex(input int off, input string nm, input logic [4:0] s, input logic [1:0] t);
        exp_t n;
        n.tag = cyc + off;
        n.nm  = nm;
        n.v   = {s, t};
        q.push_back(n);
    endtask

    task automatic drive(input logic [2:0] d, input logic v, input logic p, input logic r);
        @(negedge clk);
        io.in       = d;
        io.in_valid = v;
        io.prog_en  = p;
        io.relock   = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic code4(input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic [2:0] d);
        drive(a, 1'b1, 1'b0, 1'b0);
        drive(b, 1'b1, 1'b0, 1'b0);
        drive(c, 1'b1, 1'b0, 1'b0);
        drive(d, 1'b1, 1'b0, 1'b0);
    endtask

    // Reset pulse placed entirely between clock edges.
    task automatic rst_pulse();
        @(negedge clk);
        io.in       = 3'd0;
        io.in_valid = 1'b0;
        io.prog_en  = 1'b0;
        io.relock   = 1'b0;
        #2 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    initial begin
        int guard;
        reset       = 1'b0;
        io.in       = 3'd0;
        io.in_valid = 1'b0;
        io.prog_en  = 1'b0;
        io.relock   = 1'b0;
        @(negedge clk);
        ex(1, "reset_state", S_IDLE, 2'd3);
        @(negedge clk);
        reset = 1'b1;

        // correct code opens for 8 cycles then auto-relocks
        code4(3'd1, 3'd2, 3'd3, 3'd5);
        for (int i = 1; i <= 8; i++) ex(i, "open_timer", S_OPEN, 2'd3);
        ex(9, "auto_relock", S_IDLE, 2'd3);
        idle(9);

        // three wrong codes -> lockout; correct code ignored during it
        code4(3'd1, 3'd2, 3'd3, 3'd4);
        ex(1, "wrong1", S_IDLE, 2'd2);
        code4(3'd1, 3'd2, 3'd3, 3'd4);
        ex(1, "wrong2", S_IDLE, 2'd1);
        code4(3'd1, 3'd2, 3'd3, 3'd4);
        for (int i = 1; i <= 12; i++) ex(i, "lockout", S_LOCK, 2'd0);
        ex(13, "lockout_end", S_IDLE, 2'd3);
        code4(3'd1, 3'd2, 3'd3, 3'd5);
        idle(9);

        // relock on 3rd open cycle, then relock beats prog_en
        code4(3'd1, 3'd2, 3'd3, 3'd5);
        for (int i = 1; i <= 3; i++) ex(i, "open_pre_relock", S_OPEN, 2'd3);
        ex(4, "relock", S_IDLE, 2'd3);
        idle(2);
        drive(3'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        code4(3'd1, 3'd2, 3'd3, 3'd5);
        ex(1, "open_prio", S_OPEN, 2'd3);
        ex(2, "relock_prio", S_IDLE, 2'd3);
        drive(3'd0, 1'b0, 1'b1, 1'b1);
        idle(1);

        // program 7,6,5,4
        code4(3'd1, 3'd2, 3'd3, 3'd5);
        ex(1, "open_prog", S_OPEN, 2'd3);
        for (int i = 2; i <= 5; i++) ex(i, "program", S_PROG, 2'd3);
        ex(6, "prog_done", S_IDLE, 2'd3);
        drive(3'd0, 1'b0, 1'b1, 1'b0);
        code4(3'd7, 3'd6, 3'd5, 3'd4);
        idle(1);
        code4(3'd1, 3'd2, 3'd3, 3'd5);
        ex(1, "old_code", S_IDLE, 2'd2);
        code4(3'd7, 3'd6, 3'd5, 3'd4);
        ex(1, "new_code", S_OPEN, 2'd3);
        ex(2, "relock_new", S_IDLE, 2'd3);
        drive(3'd0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // reset during lockout
        code4(3'd1, 3'd2, 3'd3, 3'd4);
        ex(1, "l_wrong1", S_IDLE, 2'd2);
        code4(3'd1, 3'd2, 3'd3, 3'd4);
        ex(1, "l_wrong2", S_IDLE, 2'd1);
        code4(3'd1, 3'd2, 3'd3, 3'd4);
        ex(1, "l_lock1", S_LOCK, 2'd0);
        ex(2, "l_lock2", S_LOCK, 2'd0);
        idle(2);
        rst_pulse();
        ex(1, "rst_lockout", S_IDLE, 2'd3);

        // partial entry times out; default code restored by reset
        drive(3'd1, 1'b1, 1'b0, 1'b0);
        drive(3'd2, 1'b1, 1'b0, 1'b0);
        idle(16);
        ex(1, "timeout_tries", S_IDLE, 2'd3);
        code4(3'd1, 3'd2, 3'd3, 3'd5);
        ex(1, "open_after_to", S_OPEN, 2'd3);
        ex(2, "relock_to", S_IDLE, 2'd3);
        drive(3'd0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // reset mid-program keeps default code
        code4(3'd1, 3'd2, 3'd3, 3'd5);
        ex(1, "open_p2", S_OPEN, 2'd3);
        ex(2, "prog_p2", S_PROG, 2'd3);
        drive(3'd0, 1'b0, 1'b1, 1'b0);
        drive(3'd6, 1'b1, 1'b0, 1'b0);
        drive(3'd6, 1'b1, 1'b0, 1'b0);
        rst_pulse();
        ex(1, "rst_program", S_IDLE, 2'd3);
        code4(3'd1, 3'd2, 3'd3, 3'd5);
        ex(1, "default_code", S_OPEN, 2'd3);
        ex(2, "relock_end", S_IDLE, 2'd3);
        drive(3'd0, 1'b0, 1'b0, 1'b1);
        idle(1);

        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/param_locksystem.md
Name: param_locksystem

Overview:
- Parametrised digital combination lock controller; successor to the fixed 3-bit lock FSM.
- Accepts digit strobes and compares them against a stored, reprogrammable code. Drives lock/alarm/status outputs to the door actuator and the switch-select mux.
- Adds over the previous generation: generic digit width and code length, failed-attempt counter with timed lockout, auto-relock timer, entry timeout, and in-field code programming.

Parameters:
- DIGIT_W, 3, bits per digit.
- CODE_LEN, 4, digits per code.
- DEFAULT_CODE, {3'd1,3'd2,3'd3,3'd5}, reset code (CODE_LEN*DIGIT_W bits); first digit in MSBs.
- MAX_TRIES, 3, consecutive failed codes before lockout (>=1).
- UNLOCK_CYCLES, 8, cycles the lock stays open before auto-relock.
- LOCKOUT_CYCLES, 12, cycles of alarm/lockout.
- ENTRY_TIMEOUT, 16, idle cycles allowed between digits before a partial entry is discarded.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in  input  DIGIT_W  digit value, sampled when in_valid=1.
- in_valid  input  1  one-cycle digit strobe.
- prog_en  input  1  request code programming; honoured only in OPEN.
- relock  input  1  immediate relock request; honoured only in OPEN.
- locked  output  1  1 = door locked.
- alarm  output  1  1 during lockout.
- selsw  output  2  state code: 00 IDLE/ENTRY, 01 OPEN, 10 LOCKOUT, 11 PROGRAM.
- entimer  output  1  1 while the OPEN or LOCKOUT timer is counting.
- tries_left  output  clog2(MAX_TRIES+1)  remaining attempts before lockout.

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - locked=1, alarm=0, selsw=00, entimer=0, tries_left=MAX_TRIES.
  - Code register=DEFAULT_CODE; digit index, all timers and the shadow register cleared.
  - Reset asserted mid-operation aborts any entry, timer or programming immediately.
- All outputs are registered and reflect the state one edge after the causing event.
- IDLE: in_valid -> store digit 0, index=1, go to ENTRY.
- ENTRY:
  - Each in_valid stores the digit at the current index and increments the index.
  - On the edge accepting digit CODE_LEN-1, the full entry is compared to the code register.
  - Match: go to OPEN, tries_left=MAX_TRIES, timer loaded to UNLOCK_CYCLES-1.
  - Mismatch with tries_left>1: decrement tries_left, return to IDLE.
  - Mismatch with tries_left=1: tries_left=0, go to LOCKOUT, timer loaded to LOCKOUT_CYCLES-1.
  - ENTRY_TIMEOUT cycles with no in_valid: discard the partial entry and return to IDLE. A timeout does not consume a try.
- OPEN:
  - locked=0, entimer=1; timer decrements each cycle; timer=0 -> IDLE, locked=1.
  - relock=1 -> IDLE next edge. relock has priority over prog_en and expiry.
  - prog_en=1 (relock=0) -> PROGRAM, entimer=0, locked stays 0.
  - in_valid is ignored.
- LOCKOUT:
  - alarm=1, entimer=1, locked=1; in_valid, prog_en and relock are all ignored.
  - Timer expiry -> IDLE, alarm=0, tries_left=MAX_TRIES.
- PROGRAM:
  - CODE_LEN accepted digits fill a shadow register.
  - On the edge accepting the last digit, the shadow is copied to the code register and the state goes to IDLE, locked=1.
  - ENTRY_TIMEOUT with no digit: abandon, code unchanged, go to IDLE locked.
- Simultaneous events:
  - in_valid on the same edge as a state change is processed by the state being left.
  - A digit arriving in the cycle OPEN/LOCKOUT expires is ignored.
- All counters saturate and never wrap. tries_left never goes below 0.

Test Plan:
- Reset, then digits 1,2,3,5 on consecutive cycles -> locked=0 and selsw=01 on the cycle after the 4th digit. entimer=1 for 8 cycles, then locked=1, selsw=00.
- Digits 1,2,3,4 three times -> tries_left 2, 1, then LOCKOUT: alarm=1, selsw=10 for 12 cycles. The correct code entered during lockout is ignored. Afterwards tries_left=3.
- Open with 1,2,3,5, pulse relock on the 3rd open cycle -> locked=1 next edge. Pulse relock and prog_en together -> relock wins.
- Open, prog_en, digits 7,6,5,4 -> IDLE locked. Code 1,2,3,5 now fails (tries_left=2); 7,6,5,4 opens.
- Digits 1,2 then 16 idle cycles -> back to IDLE, tries_left unchanged at 3. Full 1,2,3,5 then opens.
- Assert reset during LOCKOUT and again mid-PROGRAM -> immediate locked=1, alarm=0, tries_left=3, code reverts to 1,2,3,5.
